// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core
// Brief    : Multicycle MIPS-subset core, one shared ALU, unified memory port
// Revision : 1.0
// ============================================================================
module multicycle_core #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           NREG     = 32
) (
    input  logic         CLK,
    input  logic         rst,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] result,
    output logic         reg_we_out,
    output logic         halted,
    output logic         illegal
);

    localparam logic [5:0]   c_OP_RTYPE = 6'b000000;
    localparam logic [5:0]   c_OP_LW    = 6'b100011;
    localparam logic [5:0]   c_OP_SW    = 6'b101011;
    localparam logic [5:0]   c_OP_BEQ   = 6'b000100;
    localparam logic [5:0]   c_OP_ADDI  = 6'b001000;
    localparam logic [5:0]   c_OP_J     = 6'b000010;
    localparam logic [5:0]   c_OP_JAL   = 6'b000011;
    localparam logic [5:0]   c_OP_HALT  = 6'b111111;
    localparam logic [5:0]   c_FN_ADD   = 6'b100000;
    localparam logic [5:0]   c_FN_SUB   = 6'b100010;
    localparam logic [5:0]   c_FN_AND   = 6'b100100;
    localparam logic [5:0]   c_FN_OR    = 6'b100101;
    localparam logic [5:0]   c_FN_SLT   = 6'b101010;
    localparam logic [5:0]   c_FN_JR    = 6'b001000;
    localparam logic [N-1:0] c_PC_STEP  = N'(4);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_EXECI, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_HALT
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_pc;
    logic [31:0]  r_ir;
    logic [N-1:0] r_mdr;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_aluout;
    logic [N-1:0] r_regs [NREG];

    logic [5:0]   w_op;
    logic [5:0]   w_funct;
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [N-1:0] w_sext;
    logic [N-1:0] w_jtarget;
    logic [N-1:0] w_alu;
    logic         w_alu_ok;
    logic         w_rf_we;
    logic [4:0]   w_rf_addr;
    logic [N-1:0] w_rf_data;
    logic         w_illegal;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_sext    = {{(N-16){r_ir[15]}}, r_ir[15:0]};
    assign w_jtarget = {r_pc[N-1:28], r_ir[25:0], 2'b00};

    always_comb begin
        w_alu    = '0;
        w_alu_ok = 1'b1;
        case (w_funct)
            c_FN_ADD: w_alu = r_a + r_b;
            c_FN_SUB: w_alu = r_a - r_b;
            c_FN_AND: w_alu = r_a & r_b;
            c_FN_OR:  w_alu = r_a | r_b;
            c_FN_SLT: w_alu = {{(N-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default:  w_alu_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = r_b;
        w_illegal = 1'b0;
        w_rf_we   = 1'b0;
        w_rf_addr = 5'd0;
        w_rf_data = '0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_ADDI:        w_next = S_EXECI;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_HALT:        w_next = S_HALT;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: w_next = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = r_aluout;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_rf_we   = 1'b1;
                w_rf_addr = w_rt;
                w_rf_data = r_mdr;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_aluout;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                if (w_funct == c_FN_JR) begin
                    w_next = S_FETCH;
                end else if (w_alu_ok) begin
                    w_next = S_ALUWB;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_ALUWB: begin
                w_rf_we   = 1'b1;
                w_rf_addr = w_rd;
                w_rf_data = r_aluout;
                w_next    = S_FETCH;
            end
            S_EXECI: w_next = S_IWB;
            S_IWB: begin
                w_rf_we   = 1'b1;
                w_rf_addr = w_rt;
                w_rf_data = r_aluout;
                w_next    = S_FETCH;
            end
            S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_JAL: begin
                w_rf_we   = 1'b1;
                w_rf_addr = 5'd31;
                w_rf_data = r_pc;
                w_next    = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
        // Reset forces state to FETCH; keep the request low until it is released.
        if (rst) mem_req = 1'b0;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata[31:0];
                        r_pc <= r_pc + c_PC_STEP;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluout <= r_pc + (w_sext << 2);
                end
                S_MEMADR, S_EXECI: r_aluout <= r_a + w_sext;
                S_MEMRD: begin
                    if (mem_ready) r_mdr <= mem_rdata;
                end
                S_EXEC: begin
                    if (w_funct == c_FN_JR) r_pc <= r_a;
                    else if (w_alu_ok)      r_aluout <= w_alu;
                end
                S_BRANCH: begin
                    if (r_a == r_b) r_pc <= r_aluout;
                end
                S_JUMP, S_JAL: r_pc <= w_jtarget;
                default: ;
            endcase
            // $0 stays hard-wired to zero; the strobe is still visible on the debug port.
            if (w_rf_we && (w_rf_addr != 5'd0)) r_regs[w_rf_addr] <= w_rf_data;
        end
    end

    assign pc_out     = r_pc;
    assign result     = w_rf_data;
    assign reg_we_out = w_rf_we;
    assign halted     = (r_state == S_HALT);
    assign illegal    = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_core
// Brief    : Directed program bench for multicycle_core with a wait-state memory
// Revision : 1.0
// ============================================================================
module tb_multicycle_core;

    localparam int N = 32;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;
    logic [N-1:0] pc_out;
    logic [N-1:0] result;
    logic         reg_we_out;
    logic         halted;
    logic         illegal;

    logic [31:0]  imem [256];
    logic [31:0]  dmem [256];
    logic [255:0] dval;
    logic [7:0]   w_idx;
    int           wait_n = 0;
    logic         hold   = 1'b0;
    int           wcnt;

    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] wr_q [$];
    int           wr_k [$];
    int           ill_cnt;
    logic [N-1:0] pc_at [128];
    int           st_n;
    int           st_unstable;
    logic [N-1:0] st_addr;
    logic [N-1:0] st_data;
    int           cyc;

    multicycle_core #(.N(N), .RESET_PC(32'h0), .NREG(32)) u_dut (
        .CLK        (CLK),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc_out     (pc_out),
        .result     (result),
        .reg_we_out (reg_we_out),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 CLK = ~CLK;

    // Program image plus a store overlay; wait_n wait cycles precede every completion.
    assign w_idx     = mem_addr[9:2];
    assign mem_rdata = dval[w_idx] ? dmem[w_idx] : imem[w_idx];
    assign mem_ready = mem_req && !hold && (wcnt >= wait_n);

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
            dval <= '0;
        end else begin
            if (mem_req && !mem_ready) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            if (mem_req && mem_ready && mem_we) begin
                dmem[w_idx] <= mem_wdata;
                dval[w_idx] <= 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        imem[a[9:2]] = w;
    endtask

    task automatic clr_log();
        wr_q.delete();
        wr_k.delete();
        ill_cnt     = 0;
        st_n        = 0;
        st_unstable = 0;
        st_addr     = '0;
        st_data     = '0;
        for (int i = 0; i < 128; i++) pc_at[i] = '0;
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic release_rst();
        clr_log();
        @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic run(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(posedge CLK);
            n++;
            #1;
            if (n < 128) pc_at[n] = pc_out;
            if (reg_we_out) begin
                wr_q.push_back(result);
                wr_k.push_back(n);
            end
            if (illegal) ill_cnt++;
            if (mem_req && mem_we) begin
                if (st_n == 0) begin
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                end else if (mem_addr !== st_addr || mem_wdata !== st_data) begin
                    st_unstable++;
                end
                st_n++;
            end
            if (halted) break;
        end
    endtask

    task automatic check_wr(input string tag, input int i, input logic [N-1:0] exp);
        logic [N-1:0] got;
        got = (i < wr_q.size()) ? wr_q[i] : 'x;
        check_val(tag, got, exp);
    endtask

    initial begin
        // Reset state
        clr_mem();
        #1;
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_pc", pc_out, 32'h0);
        check_val("rst_flags", {29'd0, halted, illegal, reg_we_out}, 32'd0);
        check_val("rst_result", result, 32'h0);

        // Zero-wait ALU sequence
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'b100000));
        put(32'h0C, enc_r(5'd2, 5'd1, 5'd4, 6'b101010));
        put(32'h10, enc_j(6'h3F, 26'd0));
        wait_n = 0;
        release_rst();
        run(200, cyc);
        check_val("alu_halt_cycle", cyc, 32'd18);
        check_val("alu_halted", {31'd0, halted}, 32'd1);
        check_val("alu_nwr", wr_q.size(), 32'd4);
        check_wr("alu_addi5", 0, 32'd5);
        check_wr("alu_addi_m3", 1, 32'hFFFF_FFFD);
        check_wr("alu_add", 2, 32'd2);
        check_wr("alu_slt", 3, 32'd1);
        check_val("alu_pc", pc_out, 32'h14);
        check_val("alu_mem_req_halt", {31'd0, mem_req}, 32'd0);

        // Three wait states on every transfer
        rst = 1'b1;
        clr_mem();
        put(32'h000, enc_j(6'h02, 26'h40));
        put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        put(32'h108, enc_i(6'h23, 5'd0, 5'd5, 16'd8));
        put(32'h10C, enc_j(6'h3F, 26'd0));
        wait_n = 3;
        release_rst();
        run(400, cyc);
        check_val("mem_total_cycles", cyc, 32'd39);
        check_val("mem_st_addr", st_addr, 32'd8);
        check_val("mem_st_data", st_data, 32'd5);
        check_val("mem_st_cycles", st_n, 32'd4);
        check_val("mem_st_stable", st_unstable, 32'd0);
        check_wr("mem_lw_value", 1, 32'd5);
        check_val("mem_lw_wb_cycle", (wr_k.size() > 1) ? wr_k[1] : -1, 32'd33);

        // Branches and jump
        rst = 1'b1;
        clr_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd7));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd9));
        put(32'h08, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h0C, enc_i(6'h08, 5'd0, 5'd10, 16'h111));
        put(32'h10, enc_i(6'h08, 5'd0, 5'd10, 16'h222));
        put(32'h14, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
        put(32'h18, enc_i(6'h08, 5'd0, 5'd3, 16'h33));
        put(32'h1C, enc_j(6'h02, 26'h40));
        put(32'h100, enc_i(6'h08, 5'd0, 5'd4, 16'h44));
        put(32'h104, enc_j(6'h3F, 26'd0));
        wait_n = 0;
        release_rst();
        run(200, cyc);
        check_val("br_cycles", cyc, 32'd27);
        check_val("br_taken_pc", pc_at[11], 32'h14);
        check_val("br_fall_pc", pc_at[14], 32'h18);
        check_val("j_pc", pc_at[21], 32'h100);
        check_val("br_nwr", wr_q.size(), 32'd4);
        check_wr("br_after_fall", 2, 32'h33);
        check_wr("j_target_exec", 3, 32'h44);

        // jal / jr
        rst = 1'b1;
        clr_mem();
        put(32'h00, enc_j(6'h03, 26'h20));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd7, 16'h77));
        put(32'h08, enc_j(6'h3F, 26'd0));
        put(32'h80, enc_i(6'h08, 5'd0, 5'd6, 16'h66));
        put(32'h84, enc_r(5'd31, 5'd0, 5'd0, 6'b001000));
        release_rst();
        run(200, cyc);
        check_val("jal_cycles", cyc, 32'd16);
        check_wr("jal_link", 0, 32'h4);
        check_val("jal_pc", pc_at[3], 32'h80);
        check_val("jr_pc", pc_at[10], 32'h4);
        check_wr("jr_after", 2, 32'h77);

        // Reset in the middle of a stalled lw
        rst = 1'b1;
        clr_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h23, 5'd0, 5'd5, 16'h40));
        put(32'h08, enc_j(6'h3F, 26'd0));
        release_rst();
        cyc = 0;
        while (cyc < 20) begin
            @(posedge CLK);
            cyc++;
            #1;
            if (mem_req && !mem_we && mem_addr == 32'h40) break;
        end
        hold = 1'b1;
        check_val("rl_memrd_cycle", cyc, 32'd7);
        repeat (3) @(posedge CLK);
        #1;
        check_val("rl_stalled_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rl_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("rl_pc", pc_out, 32'h0);
        clr_mem();
        put(32'h00, enc_r(5'd1, 5'd1, 5'd6, 6'b100000));
        put(32'h04, enc_j(6'h3F, 26'd0));
        hold = 1'b0;
        release_rst();
        #1;
        check_val("rl_first_fetch", {mem_req, mem_addr[30:0]}, 32'h8000_0000);
        run(100, cyc);
        check_val("rl_cycles", cyc, 32'd6);
        check_wr("rl_regs_cleared", 0, 32'd0);

        // Illegal opcode / funct and writes to $0
        rst = 1'b1;
        clr_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd3));
        put(32'h04, enc_j(6'h3E, 26'd0));
        put(32'h08, enc_r(5'd1, 5'd1, 5'd9, 6'b000111));
        put(32'h0C, enc_r(5'd1, 5'd1, 5'd0, 6'b100000));
        put(32'h10, enc_r(5'd0, 5'd1, 5'd8, 6'b100000));
        put(32'h14, enc_j(6'h3F, 26'd0));
        release_rst();
        run(200, cyc);
        check_val("ill_cycles", cyc, 32'd19);
        check_val("ill_pulses", ill_cnt, 32'd2);
        check_val("ill_nwr", wr_q.size(), 32'd3);
        check_wr("r0_strobe_value", 1, 32'd6);
        check_wr("r0_reads_zero", 2, 32'd3);
        check_val("ill_pc", pc_out, 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
